// File: rtl/pulse_burst_gen_if.sv
// Trigger-burst control/status bundle between a stimulus source and the burst generator.
// Pure wiring: no storage, so it adds no latency.
// No backpressure: start is a request that is only honoured while the generator is idle.
interface pulse_burst_gen_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] count_in;
  logic             trig_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;

  // Source side: requests bursts and watches progress.
  modport master (
    output start, abort, count_in,
    input  trig_out, busy, done, remaining
  );

  // Generator side: accepts requests and reports progress.
  modport slave (
    input  start, abort, count_in,
    output trig_out, busy, done, remaining
  );
endinterface

// File: rtl/pulse_burst_gen.sv
// Emits count_in trig pulses (HIGH_CYC high, GAP_CYC low between), then a one-clock done.
// Latency: trig_out rises one clock after an accepted start; every output is a flop.
// No backpressure: start is ignored while busy or done; abort cancels HIGH/GAP bursts.
module pulse_burst_gen #(
  parameter int WIDTH    = 4,
  parameter int HIGH_CYC = 1,
  parameter int GAP_CYC  = 1
) (
  input logic              clk,
  input logic              n_rst,
  pulse_burst_gen_if.slave bus
);

  localparam int PHASE_MAX = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
  localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [PW-1:0] HIGH_LAST = PW'(HIGH_CYC - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             trig_q,  trig_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Next state, phase count and pulses-left; outputs are decoded from the next state
  // so they can be registered alongside it.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;

    unique case (state_q)
      S_IDLE: begin
        phase_d = '0;
        rem_d   = '0;
        if (bus.start && !bus.abort) begin
          if (bus.count_in != '0) begin
            rem_d   = bus.count_in;
            state_d = S_HIGH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_HIGH: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          phase_d = '0;
          rem_d   = '0;
        end else if (phase_q == HIGH_LAST) begin
          phase_d = '0;
          // The pulse is counted as completed on its last high clock.
          rem_d   = (rem_q != '0) ? rem_q - WIDTH'(1) : '0;
          state_d = (rem_q <= WIDTH'(1)) ? S_DONE : S_GAP;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          phase_d = '0;
          rem_d   = '0;
        end else if (phase_q == GAP_LAST) begin
          phase_d = '0;
          state_d = S_HIGH;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      S_DONE: begin
        // Abort is deliberately ignored here so the done pulse always completes.
        state_d = S_IDLE;
        phase_d = '0;
        rem_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        rem_d   = '0;
      end
    endcase

    trig_d = (state_d == S_HIGH);
    busy_d = (state_d == S_HIGH) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs; reset clears everything without a clock.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      rem_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.trig_out  = trig_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Bench for pulse_burst_gen: two instances (1/1 and 3/2 phase lengths) each feeding a
// rising-edge counter; every clock the {trig,busy,done,remaining} word is compared
// against a burst timeline computed arithmetically from count, HIGH_CYC and GAP_CYC.
module tb_pulse_burst_gen;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  int checks = 0;
  int errors = 0;

  pulse_burst_gen_if #(.WIDTH(4)) ifa ();
  pulse_burst_gen_if #(.WIDTH(4)) ifb ();

  pulse_burst_gen #(.WIDTH(4), .HIGH_CYC(1), .GAP_CYC(1)) u_dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ifa.slave)
  );

  pulse_burst_gen #(.WIDTH(4), .HIGH_CYC(3), .GAP_CYC(2)) u_dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ifb.slave)
  );

  always #5 clk = ~clk;

  // Binary pulse counters on each trig_out; they survive the generator's reset.
  logic       prev_a = 1'b0;
  logic       prev_b = 1'b0;
  logic [3:0] pcnt_a = 4'd0;
  logic [3:0] pcnt_b = 4'd0;

  always @(posedge clk) begin
    if (ifa.trig_out && !prev_a) pcnt_a <= pcnt_a + 4'd1;
    prev_a <= ifa.trig_out;
    if (ifb.trig_out && !prev_b) pcnt_b <= pcnt_b + 4'd1;
    prev_b <= ifb.trig_out;
  end

  logic [3:0] exp_cnt [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic drv(input int sel, input logic s, input logic a, input int c);
    if (sel == 0) begin
      ifa.start = s; ifa.abort = a; ifa.count_in = 4'(c);
    end else begin
      ifb.start = s; ifb.abort = a; ifb.count_in = 4'(c);
    end
  endtask

  function automatic logic [6:0] obs(input int sel);
    if (sel == 0) return {ifa.trig_out, ifa.busy, ifa.done, ifa.remaining};
    return {ifb.trig_out, ifb.busy, ifb.done, ifb.remaining};
  endfunction

  function automatic logic [3:0] pcnt(input int sel);
    return (sel == 0) ? pcnt_a : pcnt_b;
  endfunction

  function automatic int hcyc(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  function automatic int gcyc(input int sel);
    return (sel == 0) ? 1 : 2;
  endfunction

  function automatic int burst_len(input int n, input int h, input int g);
    return (n == 0) ? 0 : n * h + (n - 1) * g;
  endfunction

  // Expected {trig,busy,done,remaining} i clocks after the accepted start edge.
  function automatic logic [6:0] expect_at(input int n, input int h, input int g, input int i);
    int p, l, k, r;
    p = h + g;
    l = burst_len(n, h, g);
    if (i < l) begin
      k = i / p;
      r = i % p;
      if (r < h) return {1'b1, 1'b1, 1'b0, 4'(n - k)};
      return {1'b0, 1'b1, 1'b0, 4'(n - k - 1)};
    end
    if (i == l) return 7'b001_0000;
    return 7'b000_0000;
  endfunction

  // Runs one burst; poke_at pulses start(count 9) mid-burst, abort_at asserts abort
  // before that edge (-1 disables either). Checks every clock and the pulse counter.
  task automatic run_burst(input int sel, input int n, input int poke_at,
                           input int abort_at, output int busy_seen);
    int h, g, l, rises;
    logic [6:0] e, o;
    logic prev_t;
    h = hcyc(sel);
    g = gcyc(sel);
    l = burst_len(n, h, g);
    rises = 0;
    prev_t = 1'b0;
    busy_seen = 0;
    for (int i = 0; i <= l + 1; i++) begin
      drv(sel, (i == 0) || (i == poke_at), (i == abort_at), (i == 0) ? n : 9);
      tick();
      e = (i == abort_at) ? 7'd0 : expect_at(n, h, g, i);
      o = obs(sel);
      chk($sformatf("%s n=%0d i=%0d", (sel == 0) ? "a" : "b", n, i), {25'd0, o}, {25'd0, e});
      if (o[5]) busy_seen++;
      if (e[6] && !prev_t) rises++;
      prev_t = e[6];
      if (i == abort_at) break;
    end
    drv(sel, 1'b0, 1'b0, 0);
    exp_cnt[sel] = exp_cnt[sel] + 4'(rises);
    chk($sformatf("cnt_%s n=%0d", (sel == 0) ? "a" : "b", n),
        {28'd0, pcnt(sel)}, {28'd0, exp_cnt[sel]});
  endtask

  initial begin
    int bs, sel, n, l, poke, ab, rises;
    exp_cnt[0] = 4'd0;
    exp_cnt[1] = 4'd0;

    // Reset with start held on instance a.
    drv(0, 1'b1, 1'b0, 4);
    drv(1, 1'b0, 1'b0, 0);
    tick();
    tick();
    chk("rst_a", {25'd0, obs(0)}, 32'd0);
    chk("rst_b", {25'd0, obs(1)}, 32'd0);
    n_rst = 1'b1;
    #2;
    chk("rel_a", {25'd0, obs(0)}, 32'd0);
    chk("rel_b", {25'd0, obs(1)}, 32'd0);

    // Basic 4-pulse burst: 1010101 then done.
    run_burst(0, 4, -1, -1, bs);
    chk("busy4", bs, 7);

    // Zero-length and maximum-length bursts.
    run_burst(0, 0, -1, -1, bs);
    chk("busy0", bs, 0);
    run_burst(0, 15, -1, -1, bs);
    chk("busy15", bs, 29);

    // Longer phases, with a start attempt mid-burst.
    run_burst(1, 2, 3, -1, bs);
    chk("busy_b2", bs, 8);

    // Abort in the 3rd HIGH, then restart on the very next clock.
    run_burst(0, 6, -1, 5, bs);
    run_burst(0, 3, -1, -1, bs);
    // Abort cutting a 3-clock HIGH phase short.
    run_burst(1, 3, -1, 6, bs);
    run_burst(1, 1, -1, -1, bs);

    // Asynchronous reset after two pulses of a 5-pulse burst.
    rises = 0;
    for (int i = 0; i < 4; i++) begin
      drv(0, (i == 0), 1'b0, 5);
      tick();
      chk($sformatf("pre_rst i=%0d", i), {25'd0, obs(0)}, {25'd0, expect_at(5, 1, 1, i)});
      if (i == 0 || i == 2) rises++;
    end
    exp_cnt[0] = exp_cnt[0] + 4'(rises);
    #3;
    n_rst = 1'b0;
    #1;
    chk("async_clr", {25'd0, obs(0)}, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();
    chk("post_rst", {25'd0, obs(0)}, 32'd0);
    tick();
    chk("no_done", {25'd0, obs(0)}, 32'd0);
    chk("cnt_rst", {28'd0, pcnt_a}, {28'd0, exp_cnt[0]});

    // Start and abort together while idle: no burst.
    drv(0, 1'b1, 1'b1, 7);
    tick();
    chk("st_ab_1", {25'd0, obs(0)}, 32'd0);
    drv(0, 1'b0, 1'b0, 0);
    tick();
    chk("st_ab_2", {25'd0, obs(0)}, 32'd0);

    // Randomised bursts with occasional mid-burst start and abort.
    for (int r = 0; r < 12; r++) begin
      sel = int'($urandom_range(0, 1));
      n = int'($urandom_range(0, 15));
      l = burst_len(n, hcyc(sel), gcyc(sel));
      poke = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, l)) : -1;
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, l)) : -1;
      run_burst(sel, n, poke, ab, bs);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
